// File: rtl/uart_tx_pio_bridge.sv
// UART transmitter fed from Nios PIO exports: toggle-handshake byte writes into a
// FIFO, serialized 8N1 LSB-first at a per-frame latched bit period.
module uart_tx_pio_bridge #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_MIN    = 4
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] pio_out,
    input  logic [15:0] divisor,
    output logic [31:0] pio_in,
    output logic        txd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    state_t        state_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [LW-1:0] wr_cnt;
    logic [LW-1:0] rd_cnt;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          prev_toggle;

    logic [7:0]    shreg;
    logic [15:0]   bit_period;
    logic [15:0]   cnt;
    logic [15:0]   div_clamped;
    logic [2:0]    bit_idx;
    logic          busy;

    logic [7:0]    wr_data;
    logic          wr_toggle;
    logic          flush;
    logic          enable;
    logic          write_evt;
    logic          push;
    logic          pop;
    logic          cnt_zero;
    logic          unused_pio_bits;

    assign wr_data         = pio_out[7:0];
    assign wr_toggle       = pio_out[8];
    assign flush           = pio_out[9];
    assign enable          = pio_out[10];
    assign unused_pio_bits = ^pio_out[31:11];

    assign level       = wr_cnt - rd_cnt;
    assign full        = (level == LW'(FIFO_DEPTH));
    assign empty       = (level == '0);
    assign cnt_zero    = (cnt == 16'd0);
    assign div_clamped = (divisor < 16'(DIV_MIN)) ? 16'(DIV_MIN) : divisor;

    // A frame may only start from IDLE or at the very end of a stop bit.
    assign write_evt = (wr_toggle != prev_toggle) && !flush;
    assign pop       = enable && !empty && !flush &&
                       ((state == IDLE) || ((state == STOP) && cnt_zero));
    assign push      = write_evt && (!full || pop);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            overflow    <= 1'b0;
            prev_toggle <= wr_toggle;
        end else begin
            prev_toggle <= wr_toggle;
            if (flush) begin
                wr_cnt   <= '0;
                rd_cnt   <= '0;
                overflow <= 1'b0;
            end else begin
                if (push)
                    wr_cnt <= wr_cnt + LW'(1);
                if (pop)
                    rd_cnt <= rd_cnt + LW'(1);
                if (write_evt && full && !pop)
                    overflow <= 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; the counters alone define which entries are valid.
    always_ff @(posedge clk_clk) begin
        if (push)
            mem[wr_cnt[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (pop) state_next = START;
            START: if (cnt_zero) state_next = DATA;
            DATA:  if (cnt_zero && (bit_idx == 3'd7)) state_next = STOP;
            STOP:  if (cnt_zero) state_next = pop ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bit period is captured at pop so a divisor change only affects later frames.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            cnt        <= 16'd0;
            bit_period <= 16'(DIV_MIN);
            shreg      <= 8'd0;
            bit_idx    <= 3'd0;
        end else if (pop) begin
            shreg      <= mem[rd_cnt[AW-1:0]];
            bit_period <= div_clamped;
            cnt        <= div_clamped - 16'd1;
            bit_idx    <= 3'd0;
        end else if (state != IDLE) begin
            if (cnt_zero) begin
                cnt <= bit_period - 16'd1;
                if (state == START) begin
                    bit_idx <= 3'd0;
                end else if ((state == DATA) && (bit_idx != 3'd7)) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                cnt <= cnt - 16'd1;
            end
        end
    end

    always_comb begin
        txd  = 1'b1;
        busy = (state != IDLE);
        unique case (state)
            START:   txd = 1'b0;
            DATA:    txd = shreg[0];
            default: txd = 1'b1;
        endcase
    end

    // The ack toggle is exactly the last sampled write toggle.
    always_comb begin
        pio_in      = 32'd0;
        pio_in[7:0] = 8'(level);
        pio_in[8]   = full;
        pio_in[9]   = empty;
        pio_in[10]  = busy;
        pio_in[11]  = overflow;
        pio_in[16]  = prev_toggle;
    end

endmodule
